uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
// - Shares one UART transmitter (DATA_VALID/BUSY handshake) between NUM_REQ byte requesters,
//   e.g. register-file read data and ALU result bytes.
// - Round-robin arbitration; captures the winner's byte and drives a one-cycle DATA_VALID strobe.
// - Tracks the transmitter through BUSY high -> BUSY low before issuing the next frame.
// - Flags a frame the transmitter never accepted. Sits in the TX clock domain, beside UART_TX.
// PARAMETERS
// - DATA_WIDTH   8   frame payload width
// - NUM_REQ      2   number of requesters (2..8)
// - ACK_TIMEOUT  8   cycles to wait for TX_BUSY rise after strobe (>=1)
// PORTS
// - CLK          in   1                  single clock, all logic posedge
// - RST          in   1                  asynchronous, active-high reset
// - EN           in   1                  scheduler enable; 0 blocks new grants only
// - REQ          in   NUM_REQ            level request per requester
// - REQ_DATA     in   NUM_REQ*DATA_WIDTH requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
// - GNT          out  NUM_REQ            one-hot, one-cycle pulse: byte captured
// - TX_DATA      out  DATA_WIDTH         byte to transmitter (P_DATA)
// - TX_VALID     out  1                  one-cycle strobe to transmitter DATA_VALID
// - TX_BUSY      in   1                  transmitter BUSY
// - ACTIVE_ID    out  $clog2(NUM_REQ)    index of requester owning current frame
// - ERR_TIMEOUT  out  1                  one-cycle pulse: frame dropped (no BUSY rise)
// BEHAVIOUR
// - Reset: state=IDLE; TX_VALID=0, TX_DATA=0, GNT=0, ACTIVE_ID=0, ERR_TIMEOUT=0,
//   rr_ptr=0, timeout counter=0.
// - All outputs registered. RST asserted mid-frame clears everything in the same cycle.
//   A TX_VALID strobe in flight is withdrawn.
// - IDLE: grant when EN && |REQ && !TX_BUSY.
//   - Winner w = first i with REQ[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - Next edge: TX_DATA<=REQ_DATA[w], ACTIVE_ID<=w, GNT[w]=1 and TX_VALID=1 for that
//     one cycle, rr_ptr<=(w+1) mod NUM_REQ. Go to WAIT_ACK.
// - Latency: REQ sampled at edge N -> GNT/TX_VALID high in cycle N+1.
// - Requester holds REQ_DATA stable while REQ=1 and drops or advances REQ in the GNT cycle.
//   REQ is ignored outside IDLE.
// - WAIT_ACK:
//   - Counter increments each cycle.
//   - TX_BUSY=1 -> WAIT_DONE, counter cleared.
//   - Counter reaches ACK_TIMEOUT with TX_BUSY=0 -> ERR_TIMEOUT pulse, IDLE.
//     The frame is dropped, not retried.
// - WAIT_DONE: TX_BUSY=0 -> IDLE. The earliest next grant is 1 cycle later.
//   - Frame-to-frame gap is at least 2 cycles after the BUSY fall.
// - TX_DATA holds its value from capture until the next capture; it does not change while TX_BUSY=1.
// - EN falling mid-frame: the current frame completes normally; no further grants while EN=0.
// - Single requester active: it is re-granted every frame; rr_ptr still advances.
// - TX_BUSY already high in IDLE (transmitter owned elsewhere or not yet idle): no grant until it falls.
// - Widths: counter is $clog2(ACK_TIMEOUT+1) bits and saturates.
//   rr_ptr wrap is explicit mod NUM_REQ, safe for non-power-of-2 NUM_REQ.
// STRUCTURE
// - Package uart_sched_pkg:
//   - sched_state_e {IDLE, WAIT_ACK, WAIT_DONE}, 2-bit encoding.
//   - Default localparams for DATA_WIDTH/ACK_TIMEOUT.
// - Sub-module rr_arbiter #(NUM_REQ): combinational req + ptr -> one-hot grant + index, valid.
//   Reused by other shared-resource blocks.
// - Top holds the FSM, capture register, timeout counter and rr_ptr register.
// TESTING
// - Single req: REQ=01, REQ_DATA[0]=8'hA5, TX_BUSY idle ->
//   GNT=01 and TX_VALID=1, TX_DATA=A5 one cycle later. Model BUSY 1..10 cycles -> back to IDLE.
// - Contention: REQ=11 held, data 8'h11/8'h22, rr_ptr=0 ->
//   frames 11,22,11,22 in order; GNT alternates 01,10.
// - Timeout: TX_BUSY stuck 0 after strobe, ACK_TIMEOUT=8 ->
//   ERR_TIMEOUT pulse at cycle 8 after TX_VALID; IDLE; next REQ is granted normally.
// - Blocking: TX_BUSY=1 in IDLE with REQ=01 -> no GNT. TX_BUSY falls -> GNT next cycle.
// - EN drop: EN->0 during WAIT_DONE with REQ=10 -> frame completes, no new GNT.
//   EN->1 -> grant requester 1.
// - Reset mid-frame: RST pulse in WAIT_DONE -> all outputs 0 immediately, rr_ptr=0.
//   After release with REQ=11 -> requester 0 is granted first.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and defaults for the UART TX scheduler and its arbiter.
//   sched_state_e   : scheduler FSM state, 2-bit encoding
//   DEF_*           : default parameter values
//   wrap_add()      : (base + off) mod n, safe for non-power-of-2 n
package uart_sched_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_NUM_REQ     = 2;
    localparam int DEF_ACK_TIMEOUT = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } sched_state_e;

    function automatic int wrap_add(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester / transmitter handshake bundle for uart_tx_scheduler.
//   master : requesters + transmitter side (drives en, req, req_data, tx_busy)
//   slave  : scheduler side (drives gnt, tx_data, tx_valid, active_id, err_timeout)
interface uart_tx_scheduler_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 2
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                          en;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_valid;
    logic                          tx_busy;
    logic [IDW-1:0]                active_id;
    logic                          err_timeout;

    modport master (
        output en, req, req_data, tx_busy,
        input  gnt, tx_data, tx_valid, active_id, err_timeout
    );

    modport slave (
        input  en, req, req_data, tx_busy,
        output gnt, tx_data, tx_valid, active_id, err_timeout
    );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request found
// searching from ptr_i upwards (wrapping mod NUM_REQ) wins.
//   req_i   : request vector
//   ptr_i   : highest-priority index
//   gnt_o   : one-hot grant
//   idx_o   : winner index
//   valid_o : any request present
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDW-1:0]     idx_o,
    output logic               valid_o
);

    logic [IDW-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = IDW'(wrap_add(int'(ptr_i), off, NUM_REQ));
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NUM_REQ byte requesters using
// round-robin arbitration, a one-cycle DATA_VALID strobe and BUSY tracking.
// A frame whose BUSY never rises within ACK_TIMEOUT cycles is dropped.
//   clk_i : clock, all logic on posedge
//   rst_i : asynchronous active-high reset
//   bus   : handshake bundle (slave side), see uart_tx_scheduler_if
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | waiting for EN && request && transmitter not busy
// WAIT_ACK  | strobe issued, waiting for BUSY rise (timeout armed)
// WAIT_DONE | transmitter busy with our frame, waiting for BUSY fall
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    uart_tx_scheduler_if.slave bus
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW  = $clog2(ACK_TIMEOUT + 1);

    sched_state_e          state_q;
    logic [IDW-1:0]        rr_ptr_q;
    logic [IDW-1:0]        rr_ptr_d;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic [IDW-1:0]        active_id_q;
    logic [NUM_REQ-1:0]    gnt_q;
    logic                  tx_valid_q;
    logic                  err_q;

    logic [NUM_REQ-1:0]    arb_gnt;
    logic [IDW-1:0]        arb_idx;
    logic                  arb_valid;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (bus.req),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign rr_ptr_d = IDW'(wrap_add(int'(arb_idx), 1, NUM_REQ));
    // Saturating increment; the terminal compare below fires on reaching ACK_TIMEOUT.
    assign cnt_d    = (cnt_q == CW'(ACK_TIMEOUT)) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            tx_data_q   <= '0;
            active_id_q <= '0;
            gnt_q       <= '0;
            tx_valid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            gnt_q      <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (bus.en && arb_valid && !bus.tx_busy) begin
                        tx_data_q   <= bus.req_data[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
                        active_id_q <= arb_idx;
                        gnt_q       <= arb_gnt;
                        tx_valid_q  <= 1'b1;
                        rr_ptr_q    <= rr_ptr_d;
                        state_q     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (bus.tx_busy) begin
                        cnt_q   <= '0;
                        state_q <= WAIT_DONE;
                    end else if (cnt_d == CW'(ACK_TIMEOUT)) begin
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.active_id   = active_id_q;
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler (DATA_WIDTH=8, NUM_REQ=2, ACK_TIMEOUT=8).
module tb_uart_tx_scheduler;

    logic clk;
    logic rst;

    uart_tx_scheduler_if #(.DATA_WIDTH(8), .NUM_REQ(2)) bus_if ();

    uart_tx_scheduler #(.DATA_WIDTH(8), .NUM_REQ(2), .ACK_TIMEOUT(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        en;
        logic [1:0]  req;
        logic [15:0] rdata;
        logic        busy;
        logic        e_valid;
        logic [1:0]  e_gnt;
        logic [7:0]  e_data;
        logic        e_id;
        logic        e_err;
    } vec_t;

    vec_t vecs [13];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_outs(input string name, input logic ev, input logic [1:0] eg,
                              input logic [7:0] ed, input logic eid, input logic eerr);
        check({name, ".valid"}, 32'(bus_if.tx_valid),    32'(ev));
        check({name, ".gnt"},   32'(bus_if.gnt),         32'(eg));
        check({name, ".data"},  32'(bus_if.tx_data),     32'(ed));
        check({name, ".id"},    32'(bus_if.active_id),   32'(eid));
        check({name, ".err"},   32'(bus_if.err_timeout), 32'(eerr));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic en, input logic [1:0] req, input logic [15:0] rd, input logic busy);
        bus_if.en       = en;
        bus_if.req      = req;
        bus_if.req_data = rd;
        bus_if.tx_busy  = busy;
    endtask

    initial begin
        //          name         en req    rdata     busy  valid gnt   data   id   err
        vecs[0]  = '{"grant0",    1, 2'b01, 16'h22A5, 0,    1,    2'b01, 8'hA5, 0,   0};
        vecs[1]  = '{"ack_wait",  1, 2'b00, 16'h22A5, 0,    0,    2'b00, 8'hA5, 0,   0};
        vecs[2]  = '{"busy_rise", 1, 2'b00, 16'h22A5, 1,    0,    2'b00, 8'hA5, 0,   0};
        vecs[3]  = '{"busy_hold", 1, 2'b01, 16'h22A5, 1,    0,    2'b00, 8'hA5, 0,   0};
        vecs[4]  = '{"busy_fall", 1, 2'b01, 16'h22A5, 0,    0,    2'b00, 8'hA5, 0,   0};
        vecs[5]  = '{"regrant0",  1, 2'b01, 16'h22A5, 0,    1,    2'b01, 8'hA5, 0,   0};
        vecs[6]  = '{"fast_busy", 1, 2'b00, 16'h22A5, 1,    0,    2'b00, 8'hA5, 0,   0};
        vecs[7]  = '{"done2",     1, 2'b00, 16'h22A5, 0,    0,    2'b00, 8'hA5, 0,   0};
        vecs[8]  = '{"blocked",   1, 2'b01, 16'h22A5, 1,    0,    2'b00, 8'hA5, 0,   0};
        vecs[9]  = '{"blocked2",  1, 2'b01, 16'h22A5, 1,    0,    2'b00, 8'hA5, 0,   0};
        vecs[10] = '{"unblock",   1, 2'b01, 16'h22A5, 0,    1,    2'b01, 8'hA5, 0,   0};
        vecs[11] = '{"ack3",      1, 2'b00, 16'h22A5, 1,    0,    2'b00, 8'hA5, 0,   0};
        vecs[12] = '{"done3",     1, 2'b00, 16'h22A5, 0,    0,    2'b00, 8'hA5, 0,   0};

        rst = 1'b1;
        drive(1'b0, 2'b00, 16'h0000, 1'b0);
        step();
        step();
        check_outs("reset", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;

        // Single requester, re-grant, blocking by BUSY already high in IDLE
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].en, vecs[i].req, vecs[i].rdata, vecs[i].busy);
            step();
            check_outs(vecs[i].name, vecs[i].e_valid, vecs[i].e_gnt, vecs[i].e_data,
                       vecs[i].e_id, vecs[i].e_err);
        end

        // Timeout: requester 1 granted (rr_ptr=1), BUSY never rises
        drive(1'b1, 2'b10, 16'h22A5, 1'b0);
        step();
        check_outs("to_grant", 1'b1, 2'b10, 8'h22, 1'b1, 1'b0);
        drive(1'b1, 2'b00, 16'h22A5, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("to_err_c%0d", i), 32'(bus_if.err_timeout), 32'(i == 8));
            check($sformatf("to_valid_c%0d", i), 32'(bus_if.tx_valid), 32'd0);
        end
        drive(1'b1, 2'b01, 16'h22A5, 1'b0);
        step();
        check_outs("to_next", 1'b1, 2'b01, 8'hA5, 1'b0, 1'b0);

        // EN drop during WAIT_DONE with REQ=10 pending
        drive(1'b1, 2'b00, 16'h22A5, 1'b1);
        step();
        drive(1'b0, 2'b10, 16'h22A5, 1'b1);
        step();
        check("en_hold_gnt", 32'(bus_if.gnt), 32'd0);
        drive(1'b0, 2'b10, 16'h22A5, 1'b0);
        step();
        check("en_done_gnt", 32'(bus_if.gnt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("en_off_gnt%0d", i), 32'(bus_if.gnt), 32'd0);
            check($sformatf("en_off_valid%0d", i), 32'(bus_if.tx_valid), 32'd0);
        end
        drive(1'b1, 2'b10, 16'h22A5, 1'b0);
        step();
        check_outs("en_back", 1'b1, 2'b10, 8'h22, 1'b1, 1'b0);

        // Frame from requester 0 leaves rr_ptr=1, then reset in WAIT_DONE
        drive(1'b1, 2'b00, 16'h22A5, 1'b1);
        step();
        drive(1'b1, 2'b00, 16'h22A5, 1'b0);
        step();
        drive(1'b1, 2'b01, 16'h22A5, 1'b0);
        step();
        check_outs("pre_rst", 1'b1, 2'b01, 8'hA5, 1'b0, 1'b0);
        drive(1'b1, 2'b00, 16'h22A5, 1'b1);
        step();
        rst = 1'b1;
        #1;
        check_outs("rst_async", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
        step();
        drive(1'b1, 2'b11, 16'h2211, 1'b0);
        rst = 1'b0;

        // Contention with both requesters held: 11,22,11,22
        for (int k = 0; k < 4; k++) begin
            logic [7:0] ed;
            ed = (k % 2 == 0) ? 8'h11 : 8'h22;
            step();
            check_outs($sformatf("rr%0d", k), 1'b1, (k % 2 == 0) ? 2'b01 : 2'b10, ed,
                       1'(k % 2), 1'b0);
            bus_if.tx_busy = 1'b0;
            step();
            bus_if.tx_busy = 1'b1;
            step();
            step();
            check($sformatf("rr%0d_hold", k), 32'(bus_if.tx_data), 32'(ed));
            check($sformatf("rr%0d_nognt", k), 32'(bus_if.gnt), 32'd0);
            bus_if.tx_busy = 1'b0;
            step();
            check($sformatf("rr%0d_gap", k), 32'(bus_if.tx_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
